// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared MIPS pipeline definitions: ALUOp/Funct codes and the control bundle
// carried from ID through EX/MEM and MEM/WB.
package mips_pkg;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Main-control outputs, RegWrite first so later stages can slice off
  // the fields they no longer need.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W  = $bits(ctrl_t);
  localparam int FUNCT_W = 6;

endpackage

// File: rtl/id_ex_pipeline_register_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
// master = the ID stage / driver, slave = the pipeline register itself.
interface id_ex_pipeline_register_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) ();

  logic                  ID_Valid;
  logic                  ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite;
  logic                  ID_Branch, ID_ALUSrc, ID_RegDst;
  logic [1:0]            ID_ALUOp;
  logic [5:0]            ID_Funct;
  logic [DATA_W-1:0]     ID_PC4, ID_ReadData1, ID_ReadData2, ID_SignImm;
  logic [REG_ADDR_W-1:0] ID_Rs, ID_Rt, ID_Rd;

  logic                  EX_Valid;
  logic                  EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite;
  logic                  EX_Branch, EX_ALUSrc, EX_RegDst;
  logic [1:0]            EX_ALUOp;
  logic [5:0]            EX_Funct;
  logic [DATA_W-1:0]     EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignImm;
  logic [REG_ADDR_W-1:0] EX_Rs, EX_Rt, EX_Rd;

  modport master (
    output ID_Valid, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
           ID_Branch, ID_ALUSrc, ID_RegDst, ID_ALUOp, ID_Funct,
           ID_PC4, ID_ReadData1, ID_ReadData2, ID_SignImm, ID_Rs, ID_Rt, ID_Rd,
    input  EX_Valid, EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite,
           EX_Branch, EX_ALUSrc, EX_RegDst, EX_ALUOp, EX_Funct,
           EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignImm, EX_Rs, EX_Rt, EX_Rd
  );

  modport slave (
    input  ID_Valid, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite,
           ID_Branch, ID_ALUSrc, ID_RegDst, ID_ALUOp, ID_Funct,
           ID_PC4, ID_ReadData1, ID_ReadData2, ID_SignImm, ID_Rs, ID_Rt, ID_Rd,
    output EX_Valid, EX_RegWrite, EX_MemtoReg, EX_MemRead, EX_MemWrite,
           EX_Branch, EX_ALUSrc, EX_RegDst, EX_ALUOp, EX_Funct,
           EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignImm, EX_Rs, EX_Rt, EX_Rd
  );

endinterface

// File: rtl/id_ex_pipeline_register_pipe_reg.sv
// Generic pipeline flop: synchronous active-low reset, then clear, then
// enable. Shared by all inter-stage registers of the pipeline.
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q, data_d;

  // Next state: clear beats enable; with neither, hold.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register. Reset > flush > stall > load. A load of an
// invalid ID slot is turned into a zeroed bubble so nothing downstream
// can write the register file or memory on its behalf.
module id_ex_pipeline_register
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Stall,
  input  logic                       Flush,
  id_ex_pipeline_register_if.slave   bus
);

  localparam int CW = 1 + CTRL_W + FUNCT_W;
  localparam int DW = 4 * DATA_W + 3 * REG_ADDR_W;

  ctrl_t           id_ctrl, ex_ctrl;
  logic [CW-1:0]   ctrl_d, ctrl_q;
  logic [DW-1:0]   data_d, data_q;
  logic            bubble;
  logic            load_en;

  // A stalled invalid slot must still hold, so the ID_Valid bubble only
  // applies when the register is actually loading.
  assign bubble  = Flush | (~Stall & ~bus.ID_Valid);
  assign load_en = ~Stall;

  assign id_ctrl.reg_write  = bus.ID_RegWrite;
  assign id_ctrl.mem_to_reg = bus.ID_MemtoReg;
  assign id_ctrl.mem_read   = bus.ID_MemRead;
  assign id_ctrl.mem_write  = bus.ID_MemWrite;
  assign id_ctrl.branch     = bus.ID_Branch;
  assign id_ctrl.alu_src    = bus.ID_ALUSrc;
  assign id_ctrl.reg_dst    = bus.ID_RegDst;
  assign id_ctrl.alu_op     = bus.ID_ALUOp;

  assign ctrl_d = {bus.ID_Valid, id_ctrl, bus.ID_Funct};
  assign data_d = {bus.ID_PC4, bus.ID_ReadData1, bus.ID_ReadData2,
                   bus.ID_SignImm, bus.ID_Rs, bus.ID_Rt, bus.ID_Rd};

  pipe_reg #(.WIDTH(CW)) u_ctrl_reg (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .clr_i  (bubble),
    .en_i   (load_en),
    .d_i    (ctrl_d),
    .q_o    (ctrl_q)
  );

  pipe_reg #(.WIDTH(DW)) u_data_reg (
    .clk_i  (Clk),
    .rst_ni (Rst_n),
    .clr_i  (bubble),
    .en_i   (load_en),
    .d_i    (data_d),
    .q_o    (data_q)
  );

  assign {bus.EX_Valid, ex_ctrl, bus.EX_Funct} = ctrl_q;

  assign bus.EX_RegWrite = ex_ctrl.reg_write;
  assign bus.EX_MemtoReg = ex_ctrl.mem_to_reg;
  assign bus.EX_MemRead  = ex_ctrl.mem_read;
  assign bus.EX_MemWrite = ex_ctrl.mem_write;
  assign bus.EX_Branch   = ex_ctrl.branch;
  assign bus.EX_ALUSrc   = ex_ctrl.alu_src;
  assign bus.EX_RegDst   = ex_ctrl.reg_dst;
  assign bus.EX_ALUOp    = ex_ctrl.alu_op;

  assign {bus.EX_PC4, bus.EX_ReadData1, bus.EX_ReadData2,
          bus.EX_SignImm, bus.EX_Rs, bus.EX_Rt, bus.EX_Rd} = data_q;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Testbench for id_ex_pipeline_register: directed scenarios followed by a
// random stream, checked against a whole-bundle reference model.
module tb_id_ex_pipeline_register;

  typedef struct packed {
    logic        valid;
    logic        regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } bundle_t;

  logic Clk, Rst_n, Stall, Flush;
  int   tests = 0;
  int   fails = 0;
  bundle_t model;

  id_ex_pipeline_register_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  id_ex_pipeline_register #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Stall (Stall),
    .Flush (Flush),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic drive(input bundle_t b);
    bus.ID_Valid = b.valid;       bus.ID_RegWrite = b.regwrite;
    bus.ID_MemtoReg = b.memtoreg; bus.ID_MemRead = b.memread;
    bus.ID_MemWrite = b.memwrite; bus.ID_Branch = b.branch;
    bus.ID_ALUSrc = b.alusrc;     bus.ID_RegDst = b.regdst;
    bus.ID_ALUOp = b.aluop;       bus.ID_Funct = b.funct;
    bus.ID_PC4 = b.pc4;           bus.ID_ReadData1 = b.rd1;
    bus.ID_ReadData2 = b.rd2;     bus.ID_SignImm = b.imm;
    bus.ID_Rs = b.rs; bus.ID_Rt = b.rt; bus.ID_Rd = b.rd;
  endtask

  function automatic bundle_t ex_bundle();
    bundle_t o;
    o.valid = bus.EX_Valid;       o.regwrite = bus.EX_RegWrite;
    o.memtoreg = bus.EX_MemtoReg; o.memread = bus.EX_MemRead;
    o.memwrite = bus.EX_MemWrite; o.branch = bus.EX_Branch;
    o.alusrc = bus.EX_ALUSrc;     o.regdst = bus.EX_RegDst;
    o.aluop = bus.EX_ALUOp;       o.funct = bus.EX_Funct;
    o.pc4 = bus.EX_PC4;           o.rd1 = bus.EX_ReadData1;
    o.rd2 = bus.EX_ReadData2;     o.imm = bus.EX_SignImm;
    o.rs = bus.EX_Rs; o.rt = bus.EX_Rt; o.rd = bus.EX_Rd;
    return o;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.valid = ($urandom_range(3) != 0);
    b.regwrite = 1'($urandom); b.memtoreg = 1'($urandom);
    b.memread = 1'($urandom);  b.memwrite = 1'($urandom);
    b.branch = 1'($urandom);   b.alusrc = 1'($urandom);
    b.regdst = 1'($urandom);   b.aluop = 2'($urandom);
    b.funct = 6'($urandom);    b.pc4 = $urandom;
    b.rd1 = $urandom; b.rd2 = $urandom; b.imm = $urandom;
    b.rs = 5'($urandom); b.rt = 5'($urandom); b.rd = 5'($urandom);
    return b;
  endfunction

  task automatic check_field(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply controls and ID bundle, advance the model, compare the
  // full EX bundle and the bubble invariant.
  task automatic step(input logic rst_n, input logic stall, input logic flush,
                      input bundle_t b, input string tag);
    bundle_t obs;
    Rst_n = rst_n; Stall = stall; Flush = flush;
    drive(b);
    @(posedge Clk);
    if (!rst_n || flush) model = '0;
    else if (!stall)     model = b.valid ? b : '0;
    #1;
    obs = ex_bundle();
    tests++;
    assert (obs === model) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, model);
    end
    tests++;
    assert ((obs.valid | ~(obs.regwrite | obs.memread | obs.memwrite | obs.branch)) === 1'b1)
    else begin
      fails++;
      $error("FAIL %s_bubble_inv: observed v=%b rw=%b mr=%b mw=%b br=%b expected no side effects",
             tag, obs.valid, obs.regwrite, obs.memread, obs.memwrite, obs.branch);
    end
    $display("[TB] %s rst_n=%b stall=%b flush=%b ex=%h", tag, rst_n, stall, flush, obs);
  endtask

  initial begin
    bundle_t ones, b, lw, sw;
    ones = '1;
    model = '0;
    Rst_n = 1'b0; Stall = 1'b0; Flush = 1'b0;
    drive(ones);

    // Reset with all-ones inputs, then release
    step(1'b0, 1'b0, 1'b0, ones, "reset0");
    step(1'b0, 1'b0, 1'b0, ones, "reset1");
    check_field(32'(bus.EX_Valid), 32'd0, "reset_valid");
    step(1'b1, 1'b0, 1'b0, ones, "release_load");
    check_field(32'(bus.EX_ALUOp), 32'h3, "release_aluop");
    check_field(32'(bus.EX_Funct), 32'h3F, "release_funct");
    check_field(32'(bus.EX_Valid), 32'd1, "release_valid");

    // R-type add
    b = '0; b.valid = 1'b1; b.aluop = 2'b10; b.funct = 6'b100000;
    b.rd1 = 32'h0000_0005; b.rd = 5'd3; b.regwrite = 1'b1; b.regdst = 1'b1;
    step(1'b1, 1'b0, 1'b0, b, "rtype_add");
    check_field(32'(bus.EX_Rd), 32'd3, "rtype_rd");
    check_field(bus.EX_ReadData1, 32'h5, "rtype_rd1");

    // lw, then 3 stalled cycles with sw on ID, then release
    lw = '0; lw.valid = 1'b1; lw.memread = 1'b1; lw.memtoreg = 1'b1;
    lw.regwrite = 1'b1; lw.alusrc = 1'b1; lw.imm = 32'h0000_0010; lw.rt = 5'd8;
    sw = '0; sw.valid = 1'b1; sw.memwrite = 1'b1; sw.alusrc = 1'b1;
    sw.imm = 32'h0000_0020; sw.rt = 5'd9; sw.pc4 = 32'h0000_0104;
    step(1'b1, 1'b0, 1'b0, lw, "lw_load");
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, sw, "stall_hold");
      check_field(bus.EX_SignImm, 32'h10, "stall_imm");
    end
    step(1'b1, 1'b0, 1'b0, sw, "sw_after_stall");
    check_field(32'(bus.EX_MemWrite), 32'd1, "sw_memwrite");

    // beq then flush
    b = '0; b.valid = 1'b1; b.aluop = 2'b01; b.branch = 1'b1; b.imm = 32'hFFFF_FFFC;
    step(1'b1, 1'b0, 1'b0, b, "beq_load");
    step(1'b1, 1'b0, 1'b1, b, "flush");
    check_field(32'(bus.EX_Branch), 32'd0, "flush_branch");

    // Stall and flush together: bubble, not hold
    step(1'b1, 1'b0, 1'b0, lw, "lw_reload");
    step(1'b1, 1'b1, 1'b1, sw, "stall_flush");
    check_field(32'(bus.EX_Valid), 32'd0, "stall_flush_valid");

    // Invalid ID slot with side-effect controls set
    b = ones; b.valid = 1'b0;
    step(1'b1, 1'b0, 1'b0, b, "id_invalid");
    check_field(32'(bus.EX_RegWrite), 32'd0, "invalid_regwrite");
    check_field(32'(bus.EX_MemWrite), 32'd0, "invalid_memwrite");

    // Random stream
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(49) != 0), ($urandom_range(3) == 0),
           ($urandom_range(7) == 0), rand_bundle(), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_register.md
Name: id_ex_pipeline_register

Overview:
- Pipeline register between the ID stage (main control decode and register-file read) and the EX stage of the 5-stage MIPS pipeline.
- Captures ID-stage control, operands and register addresses on each clock edge, and presents them to EX.
- EX_ALUOp and EX_Funct feed the ALU control unit directly.
- Supports stall (hold), flush (bubble insertion) and a valid bit so EX logic can tell real instructions from bubbles.

Parameters:
DATA_W, 32, width of PC+4, register operands and sign-extended immediate
REG_ADDR_W, 5, width of register specifiers Rs/Rt/Rd

Ports:
Clk  input  1  system clock, all state updates on rising edge
Rst_n  input  1  synchronous active-low reset
Stall  input  1  hold current contents (from hazard unit)
Flush  input  1  load a bubble (from hazard/branch logic)
ID_Valid  input  1  ID stage holds a real instruction
ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_Branch, ID_ALUSrc, ID_RegDst  input  1 each  main-control signals
ID_ALUOp  input  2  00 = load/store add, 01 = branch compare, 10 = R-type use Funct
ID_Funct  input  6  instruction bits [5:0]
ID_PC4  input  DATA_W  PC+4 of the instruction
ID_ReadData1, ID_ReadData2  input  DATA_W  register-file outputs
ID_SignImm  input  DATA_W  sign-extended immediate
ID_Rs, ID_Rt, ID_Rd  input  REG_ADDR_W  register specifiers
EX_Valid  output  1  registered valid
EX_<each control above>  output  1 or 2  registered copies, same widths
EX_Funct  output  6  registered funct
EX_PC4, EX_ReadData1, EX_ReadData2, EX_SignImm  output  DATA_W  registered data
EX_Rs, EX_Rt, EX_Rd  output  REG_ADDR_W  registered specifiers

Behaviour:
- Single clock Clk. Reset is synchronous, active-low Rst_n. No async paths; all outputs driven directly from flops.
- Latency: exactly 1 cycle from ID_* to EX_* when loading.
- Per rising edge, priority is reset > flush > stall > load:
  - Rst_n=0: every output = 0, including EX_Valid=0 and EX_ALUOp=00.
  - Flush=1: bubble. All control outputs, EX_ALUOp, EX_Funct and EX_Valid = 0. Data and specifier fields also = 0, for deterministic compare.
  - Stall=1 (no flush): all outputs hold their previous values.
  - Otherwise: load.
- Load with ID_Valid=0: treated as a bubble. Same zeroing as Flush.
- Load with ID_Valid=1: every EX_* = corresponding ID_*, and EX_Valid=1.
- Stall and Flush both 1: flush wins. A bubble enters EX; the ID stage is held by upstream logic, not by this block.
- Bubble invariant: EX_Valid=0 implies RegWrite=MemRead=MemWrite=Branch=0. A bubble must never write the register file or memory.
- Stall for N consecutive cycles holds the same contents for N cycles. The first cycle after Stall deasserts loads the ID values present in that cycle.
- Reset deasserted mid-stream: the first edge with Rst_n=1 performs a normal load/flush/stall evaluation. No extra dead cycle.
- ALUOp and Funct pass through unmodified; no decoding happens here. ALUOp=11 is passed through as-is.
- No arithmetic. Widths must match exactly, with no truncation or extension.

Decomposition:
- Shared package mips_pkg:
  - ALUOP_MEM=2'b00, ALUOP_BRANCH=2'b01, ALUOP_RTYPE=2'b10
  - FUNCT_ADD=6'b100000, FUNCT_SUB=6'b100010, FUNCT_AND=6'b100100, FUNCT_OR=6'b100101, FUNCT_SLT=6'b101010
  - A packed control-bundle struct (RegWrite..ALUOp), reused by EX/MEM and MEM/WB.
- One natural sub-module: pipe_reg, a generic WIDTH-parameterised flop with synchronous active-low reset, Clr and En. It is instantiated once for the control bundle plus valid, and once for the data and specifier fields. It is reused later by the other pipeline registers.

Test Plan:
- Reset: Rst_n=0 for 2 cycles with all ID_* = all-ones -> all EX_* = 0, EX_Valid=0. Release -> next edge loads the all-ones pattern (EX_ALUOp=11, EX_Funct=6'h3F, EX_Valid=1).
- Load: R-type add, ID_ALUOp=10, ID_Funct=100000, ID_ReadData1=32'h0000_0005, ID_Rd=5'd3, ID_RegWrite=1 -> identical values on EX_* one cycle later, EX_Valid=1.
- Stall: load lw (ALUOp=00, MemRead=1, SignImm=32'h0000_0010), then Stall=1 for 3 cycles with ID changed to sw -> EX holds lw fields for 3 cycles. Sw appears the cycle after Stall drops.
- Flush: EX holding a valid beq (ALUOp=01, Branch=1), Flush=1 -> next cycle all EX_* = 0, EX_Valid=0.
- Simultaneous Stall=1, Flush=1 with valid ID instruction -> bubble output (all zero), not hold.
- Bubble source: ID_Valid=0 with ID_RegWrite=1, ID_MemWrite=1 -> EX_RegWrite=0, EX_MemWrite=0, EX_Valid=0. Random stream of 1000 cycles checks the bubble invariant via assertion.
